// File: rtl/edgesr_ack_ctl_if.sv
// Port bundle between the edge set/reset flag consumer and its surroundings.
// master: the controller (edgesr_ack_ctl). slave: flag source plus local consumer.
interface edgesr_ack_ctl_if #(
  parameter int CNT_WIDTH = 4
);
  logic                 req_in;
  logic                 ack_out;
  logic                 evt_valid;
  logic                 evt_ready;
  logic [CNT_WIDTH-1:0] evt_count;
  logic                 overflow;
  logic                 tmo_err;
  logic                 err_clr;
  logic                 busy;

  modport master (
    input  req_in, evt_ready, err_clr,
    output ack_out, evt_valid, evt_count, overflow, tmo_err, busy
  );

  modport slave (
    output req_in, evt_ready, err_clr,
    input  ack_out, evt_valid, evt_count, overflow, tmo_err, busy
  );
endinterface

// File: rtl/edgesr_ack_ctl.sv
// Consumer of an asynchronous edge set/reset flag. Synchronizes the flag,
// counts each set as one pending event, returns a fixed-width ack pulse to
// clear the flag, and lets local logic pop pending events.
//
// state    | meaning
// IDLE     | waiting for synchronized flag high
// ACK      | ack_out high, ack timer counting down
// WAIT_LOW | waiting for flag to clear, timeout counting down
module edgesr_ack_ctl #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 4,
  parameter int ACK_WIDTH   = 2,
  parameter int TMO_CYCLES  = 64
) (
  input  logic              clk,
  input  logic              reset,
  edgesr_ack_ctl_if.master  bus
);

  localparam int AW = $clog2(ACK_WIDTH + 1);
  localparam int TW = $clog2(TMO_CYCLES + 1);
  localparam logic [AW-1:0]        ACK_LOAD = AW'(ACK_WIDTH);
  localparam logic [AW-1:0]        ACK_ONE  = AW'(1);
  localparam logic [TW-1:0]        TMO_LOAD = TW'(TMO_CYCLES);
  localparam logic [TW-1:0]        TMO_ONE  = TW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [AW-1:0]          ack_tmr_q, ack_tmr_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   ack_q, ack_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   tmo_err_q, tmo_err_d;
  logic                   req_s;
  logic                   inc, dec, ovf_set, tmo_set;

  assign req_s = sync_q[SYNC_STAGES-1];

  // Flag synchronizer chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req_in};
  end

  // Next-state and timer logic; the ack pulse is registered alongside the state
  always_comb begin
    state_d   = state_q;
    ack_tmr_d = ack_tmr_q;
    tmo_d     = tmo_q;
    ack_d     = 1'b0;
    inc       = 1'b0;
    tmo_set   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d   = ACK;
          ack_tmr_d = ACK_LOAD;
          ack_d     = 1'b1;
          inc       = 1'b1;
        end
      end
      ACK: begin
        if (ack_tmr_q == ACK_ONE) begin
          state_d   = WAIT_LOW;
          ack_tmr_d = '0;
          tmo_d     = TMO_LOAD;
        end else begin
          ack_tmr_d = ack_tmr_q - ACK_ONE;
          ack_d     = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!req_s) begin
          state_d = IDLE;
          tmo_d   = '0;
        end else if (tmo_q == TMO_ONE) begin
          // Flag stuck high: flag the error and return to IDLE so it re-arms
          state_d = IDLE;
          tmo_d   = '0;
          tmo_set = 1'b1;
        end else begin
          tmo_d = tmo_q - TMO_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending-event counter with saturation and sticky error flags
  always_comb begin
    dec     = (cnt_q != '0) && bus.evt_ready;
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == CNT_MAX) ovf_set = 1'b1;
      else                  cnt_d   = cnt_q + CNT_ONE;
    end else if (!inc && dec) begin
      cnt_d = cnt_q - CNT_ONE;
    end
    // A set on the same edge as err_clr takes priority
    ovf_d     = ovf_set ? 1'b1 : (bus.err_clr ? 1'b0 : ovf_q);
    tmo_err_d = tmo_set ? 1'b1 : (bus.err_clr ? 1'b0 : tmo_err_q);
  end

  // State, timer, counter and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ack_tmr_q <= '0;
      tmo_q     <= '0;
      ack_q     <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_tmr_q <= ack_tmr_d;
      tmo_q     <= tmo_d;
      ack_q     <= ack_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign bus.ack_out   = ack_q;
  assign bus.evt_count = cnt_q;
  assign bus.evt_valid = (cnt_q != '0);
  assign bus.overflow  = ovf_q;
  assign bus.tmo_err   = tmo_err_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_edgesr_ack_ctl.sv
// Directed bench for edgesr_ack_ctl: SYNC_STAGES=2, CNT_WIDTH=2, ACK_WIDTH=2, TMO_CYCLES=8.
module tb_edgesr_ack_ctl;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  edgesr_ack_ctl_if #(.CNT_WIDTH(2)) bus ();

  edgesr_ack_ctl #(
    .SYNC_STAGES(2),
    .CNT_WIDTH  (2),
    .ACK_WIDTH  (2),
    .TMO_CYCLES (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 12 && bus.ack_out !== 1'b1; i++) step();
    chk("ack_seen", 32'(bus.ack_out), 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && bus.busy !== 1'b0; i++) step();
    chk("idle_seen", 32'(bus.busy), 0);
  endtask

  // Flag source model: set the flag, clear it when the ack rises
  task automatic do_event();
    bus.req_in = 1'b1;
    wait_ack();
    bus.req_in = 1'b0;
    wait_idle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   32'(bus.ack_out),   0);
    chk({tag, "_cnt"},   32'(bus.evt_count), 0);
    chk({tag, "_valid"}, 32'(bus.evt_valid), 0);
    chk({tag, "_ovf"},   32'(bus.overflow),  0);
    chk({tag, "_tmo"},   32'(bus.tmo_err),   0);
    chk({tag, "_busy"},  32'(bus.busy),      0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset         = 1'b1;
    bus.req_in    = 1'b0;
    bus.evt_ready = 1'b0;
    bus.err_clr   = 1'b0;
    #12;
    chk_all_zero("reset");
    step();
    reset = 1'b0;
    step();

    // Single event: ack rises on the third edge after req, high for two cycles
    bus.req_in = 1'b1;
    step();
    chk("t1_ack_e1", 32'(bus.ack_out), 0);
    step();
    chk("t1_ack_e2", 32'(bus.ack_out), 0);
    step();
    chk("t1_ack_e3", 32'(bus.ack_out), 1);
    chk("t1_cnt", 32'(bus.evt_count), 1);
    chk("t1_valid", 32'(bus.evt_valid), 1);
    chk("t1_busy", 32'(bus.busy), 1);
    bus.req_in = 1'b0;
    step();
    chk("t1_ack_e4", 32'(bus.ack_out), 1);
    step();
    chk("t1_ack_e5", 32'(bus.ack_out), 0);
    chk("t1_busy_wait", 32'(bus.busy), 1);
    step();
    chk("t1_busy_e6", 32'(bus.busy), 0);
    chk("t1_cnt_end", 32'(bus.evt_count), 1);

    // Pop handshake from count 3
    do_event();
    do_event();
    chk("t2_cnt3", 32'(bus.evt_count), 3);
    bus.evt_ready = 1'b1;
    step();
    chk("t2_pop1", 32'(bus.evt_count), 2);
    step();
    chk("t2_pop2", 32'(bus.evt_count), 1);
    chk("t2_valid2", 32'(bus.evt_valid), 1);
    step();
    chk("t2_pop3", 32'(bus.evt_count), 0);
    chk("t2_valid3", 32'(bus.evt_valid), 0);
    step();
    chk("t2_pop4", 32'(bus.evt_count), 0);
    chk("t2_valid4", 32'(bus.evt_valid), 0);
    bus.evt_ready = 1'b0;

    // Saturation at 3 with overflow, then err_clr
    do_event();
    chk("t3_cnt1", 32'(bus.evt_count), 1);
    do_event();
    chk("t3_cnt2", 32'(bus.evt_count), 2);
    do_event();
    chk("t3_cnt3", 32'(bus.evt_count), 3);
    chk("t3_ovf3", 32'(bus.overflow), 0);
    do_event();
    chk("t3_cnt4", 32'(bus.evt_count), 3);
    chk("t3_ovf4", 32'(bus.overflow), 1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("t3_ovf_clr", 32'(bus.overflow), 0);
    chk("t3_cnt_clr", 32'(bus.evt_count), 3);

    // Increment and pop on the same edge at max
    bus.req_in = 1'b1;
    step();
    step();
    bus.evt_ready = 1'b1;
    step();
    bus.evt_ready = 1'b0;
    chk("t4_ack", 32'(bus.ack_out), 1);
    chk("t4_cnt", 32'(bus.evt_count), 3);
    chk("t4_ovf", 32'(bus.overflow), 0);
    bus.req_in = 1'b0;
    wait_idle();
    chk("t4_cnt_end", 32'(bus.evt_count), 3);
    chk("t4_ovf_end", 32'(bus.overflow), 0);
    bus.evt_ready = 1'b1;
    step();
    step();
    step();
    bus.evt_ready = 1'b0;
    chk("t4_drain", 32'(bus.evt_count), 0);

    // Stuck flag: timeout 8 cycles after WAIT_LOW entry, then re-armed event
    bus.req_in = 1'b1;
    step();
    step();
    step();
    chk("t5_ack1", 32'(bus.ack_out), 1);
    chk("t5_cnt1", 32'(bus.evt_count), 1);
    step();
    step();
    chk("t5_wait_ack", 32'(bus.ack_out), 0);
    chk("t5_wait_busy", 32'(bus.busy), 1);
    for (int i = 0; i < 7; i++) step();
    chk("t5_tmo_early", 32'(bus.tmo_err), 0);
    chk("t5_busy_early", 32'(bus.busy), 1);
    step();
    chk("t5_tmo_set", 32'(bus.tmo_err), 1);
    chk("t5_busy_idle", 32'(bus.busy), 0);
    chk("t5_cnt_hold", 32'(bus.evt_count), 1);
    step();
    chk("t5_ack2", 32'(bus.ack_out), 1);
    chk("t5_cnt2", 32'(bus.evt_count), 2);
    bus.req_in = 1'b0;
    wait_idle();
    chk("t5_tmo_sticky", 32'(bus.tmo_err), 1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("t5_tmo_clr", 32'(bus.tmo_err), 0);
    chk("t5_cnt_end", 32'(bus.evt_count), 2);

    // Reset during ACK with the flag still set
    bus.req_in = 1'b1;
    step();
    step();
    step();
    chk("t6_ack", 32'(bus.ack_out), 1);
    chk("t6_cnt", 32'(bus.evt_count), 3);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("t6_rst");
    step();
    reset = 1'b0;
    step();
    step();
    chk("t6_cnt_e2", 32'(bus.evt_count), 0);
    step();
    chk("t6_cnt_e3", 32'(bus.evt_count), 1);
    chk("t6_ack_e3", 32'(bus.ack_out), 1);
    bus.req_in = 1'b0;
    wait_idle();
    for (int i = 0; i < 4; i++) step();
    chk("t6_cnt_end", 32'(bus.evt_count), 1);
    chk("t6_tmo_end", 32'(bus.tmo_err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
